// File: rtl/eq_band_mixer_pkg.sv
// Shared constants, state encoding and register map for the band mixer.
// Imported by the mixer top and its rounding sub-block.
package eq_mixer_pkg;

  localparam int          NUM_BANDS     = 13;
  localparam logic [15:0] GAIN_RESET    = 16'h7FFF;
  localparam logic [31:0] ROUND_CONST   = 32'h4000;
  localparam logic [3:0]  ADDR_CLR_OVR  = 4'd13;
  localparam logic [3:0]  ADDR_CLR_PEAK = 4'd14;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_e;

endpackage

// File: rtl/eq_band_mixer_if.sv
// Band capture, gain register, sample output and status bundle.
// slave is the mixer side, master the driving side.
interface eq_band_mixer_if #(
  parameter int NUM_BANDS  = 13,
  parameter int DATA_WIDTH = 16
);

  logic [NUM_BANDS*DATA_WIDTH-1:0] bands;
  logic                            in_chan;
  logic                            in_valid;
  logic                            in_ready;
  logic                            gain_wr;
  logic [3:0]                      gain_addr;
  logic [DATA_WIDTH-1:0]           gain_data;
  logic [DATA_WIDTH-1:0]           out_data;
  logic                            out_chan;
  logic                            out_valid;
  logic                            out_ready;
  logic                            overrun;
  logic [DATA_WIDTH-1:0]           peak_abs;

  modport slave (
    input  bands, in_chan, in_valid,
    input  gain_wr, gain_addr, gain_data,
    input  out_ready,
    output in_ready, out_data, out_chan,
    output out_valid, overrun, peak_abs
  );

  modport master (
    output bands, in_chan, in_valid,
    output gain_wr, gain_addr, gain_data,
    output out_ready,
    input  in_ready, out_data, out_chan,
    input  out_valid, overrun, peak_abs
  );

endinterface

// File: rtl/eq_round_sat.sv
// Round-half-up from a Q.30 accumulator to Q1.15 with saturation.
// Purely combinational; shared with later mixing stages.
module eq_round_sat
  import eq_mixer_pkg::*;
#(
  parameter int ACC_WIDTH  = 36,
  parameter int DATA_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0]  acc_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int HI = 2 * DATA_WIDTH - 2;
  localparam int LO = DATA_WIDTH - 1;

  logic [ACC_WIDTH-1:0] r;
  logic                 ovf;

  assign r   = acc_i + ACC_WIDTH'(ROUND_CONST);
  // Result fits only if every bit above HI copies the sign at HI.
  assign ovf = r[ACC_WIDTH-1:HI] != {(ACC_WIDTH-HI){r[HI]}};

  always_comb begin
    data_o = r[HI:LO];
    if (ovf) begin
      data_o = r[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/eq_band_mixer.sv
// Per-band gain + serial MAC mixer with valid/ready output.
// EQ_MIXER_PEAK_EN adds a peak |out_data| tracker.
module eq_band_mixer
  import eq_mixer_pkg::*;
#(
  parameter int NUM_BANDS  = 13,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 36
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESET,
  eq_band_mixer_if.slave bus
);

  localparam int CW = $clog2(NUM_BANDS);
  localparam int PW = 2 * DATA_WIDTH;

  state_e                state_q, state_d;
  logic [CW-1:0]         ctr_q, ctr_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0] band_q [NUM_BANDS];
  logic [DATA_WIDTH-1:0] gain_q [NUM_BANDS];
  logic                  chan_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  out_chan_q;
  logic                  ovr_q, ovr_d;
  logic                  accept;
  logic                  last;
  logic                  clr_ovr;
  logic signed [PW-1:0]  prod;
  logic [DATA_WIDTH-1:0] rs_data;

  assign bus.in_ready = (state_q == IDLE) ||
                        (state_q == OUT && bus.out_ready);
  assign accept  = bus.in_valid && bus.in_ready;
  assign last    = ctr_q == CW'(NUM_BANDS - 1);
  assign clr_ovr = bus.gain_wr && (bus.gain_addr == ADDR_CLR_OVR);
  // Gain is read live, so a write mid-frame hits later bands only.
  assign prod    = $signed(band_q[ctr_q]) * $signed(gain_q[ctr_q]);

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MAC;
          ctr_d   = '0;
          acc_d   = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        ctr_d = ctr_q + CW'(1);
        if (last) state_d = ROUND;
      end
      ROUND: state_d = OUT;
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          if (accept) begin
            state_d = MAC;
            ctr_d   = '0;
            acc_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ovr_d = ovr_q;
    if (clr_ovr) ovr_d = 1'b0;
    if (bus.in_valid && !bus.in_ready) ovr_d = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      acc_q      <= '0;
      chan_q     <= 1'b0;
      out_q      <= '0;
      out_chan_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      acc_q   <= acc_d;
      ovr_q   <= ovr_d;
      if (accept) chan_q <= bus.in_chan;
      if (state_q == ROUND) begin
        out_q      <= rs_data;
        out_chan_q <= chan_q;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (accept) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        band_q[i] <= bus.bands[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (S_AXI_ARESET) begin
        gain_q[i] <= DATA_WIDTH'(GAIN_RESET);
      end else if (bus.gain_wr && bus.gain_addr == 4'(i)) begin
        gain_q[i] <= bus.gain_data;
      end
    end
  end

  eq_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_round_sat (
    .acc_i  (acc_q),
    .data_o (rs_data)
  );

  assign bus.out_data  = out_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = state_q == OUT;
  assign bus.overrun   = ovr_q;

`ifdef EQ_MIXER_PEAK_EN
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] peak_q, peak_d, peak_base, rs_abs;
  logic                  clr_peak;

  assign clr_peak = bus.gain_wr && (bus.gain_addr == ADDR_CLR_PEAK);

  always_comb begin
    rs_abs = rs_data;
    if (rs_data == SMIN) rs_abs = ~SMIN;
    else if (rs_data[DATA_WIDTH-1]) rs_abs = -rs_data;
    // A clear coinciding with ROUND restarts the max from this sample.
    peak_base = clr_peak ? '0 : peak_q;
    peak_d    = peak_base;
    if (state_q == ROUND && rs_abs > peak_base) peak_d = rs_abs;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) peak_q <= '0;
    else              peak_q <= peak_d;
  end

  assign bus.peak_abs = peak_q;
`else
  assign bus.peak_abs = '0;
`endif

endmodule
